// File: rtl/dtw_pkg.sv
// Shared DTW result-stream definitions.
// Used by both the core's writer side and the result reader.
package dtw_pkg;

  localparam int W_QID     = 0;
  localparam int W_POS     = 1;
  localparam int W_MIN     = 2;
  localparam int REC_WORDS = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_QID,
    RD_POS,
    RD_MIN,
    CHECK,
    EMIT
  } state_e;

  typedef struct packed {
    logic [31:0] qid;
    logic [31:0] pos;
    logic [15:0] minval;
  } res_rec_t;

endpackage

// File: rtl/dtw_result_reader_if.sv
// Result FIFO read port plus downstream record handshake.
// master = reader, slave = FIFO/downstream side.
interface dtw_result_reader_if #(
  parameter int WIDTH = 16
);
  logic             fifo_rden;
  logic             fifo_empty;
  logic [31:0]      fifo_data;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_qid;
  logic [31:0]      res_pos;
  logic [WIDTH-1:0] res_minval;

  modport master (
    output fifo_rden, res_valid,
    output res_qid, res_pos, res_minval,
    input  fifo_empty, fifo_data, res_ready
  );

  modport slave (
    input  fifo_rden, res_valid,
    input  res_qid, res_pos, res_minval,
    output fifo_empty, fifo_data, res_ready
  );
endinterface

// File: rtl/dtw_result_best.sv
// Lowest-score tracker; an update in the clear cycle still
// lands, so the emitted record becomes the new best.
module dtw_result_best
  import dtw_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             upd,
  input  res_rec_t         rec,
  output logic             best_valid,
  output logic [31:0]      best_qid,
  output logic [31:0]      best_pos,
  output logic [WIDTH-1:0] best_minval
);

  logic     valid_q, valid_d;
  res_rec_t best_q, best_d;
  logic     take;

  always_comb begin
    valid_d = valid_q;
    best_d  = best_q;
    take    = upd && (!valid_q || clear ||
              rec.minval < best_q.minval);
    if (clear) begin
      valid_d = 1'b0;
      best_d  = '0;
    end
    if (take) begin
      valid_d = 1'b1;
      best_d  = rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      best_q  <= '0;
    end else begin
      valid_q <= valid_d;
      best_q  <= best_d;
    end
  end

  assign best_valid  = valid_q;
  assign best_qid    = best_q.qid;
  assign best_pos    = best_q.pos;
  assign best_minval = best_q.minval[WIDTH-1:0];

endmodule

// File: rtl/dtw_result_reader.sv
// Drains qid/pos/min triples from the DTW result FIFO, emits
// records downstream and keeps host-visible statistics.
module dtw_result_reader
  import dtw_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  dtw_result_reader_if.master  bus,
  output logic                 best_valid,
  output logic [31:0]          best_qid,
  output logic [31:0]          best_pos,
  output logic [WIDTH-1:0]     best_minval,
  output logic [CNT_WIDTH-1:0] n_results,
  output logic [CNT_WIDTH-1:0] n_errors,
  output logic                 frame_err
);

  state_e               state_q, state_d;
  logic                 rden_q, rden_d;
  logic                 pend_q, pend_d;
  logic [31:0]          qid_q, qid_d;
  logic [31:0]          pos_q, pos_d;
  logic [31:0]          raw_q, raw_d;
  logic [CNT_WIDTH-1:0] nres_q, nres_d;
  logic [CNT_WIDTH-1:0] nerr_q, nerr_d;
  logic                 ferr_q, ferr_d;
  logic                 hs, err, rd_st;
  res_rec_t             rec;

  always_comb begin
    state_d = state_q;
    qid_d   = qid_q;
    pos_d   = pos_q;
    raw_d   = raw_q;
    hs      = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE:   if (enable) state_d = RD_QID;
      RD_QID: if (pend_q) begin
        qid_d   = bus.fifo_data;
        state_d = RD_POS;
      end
      RD_POS: if (pend_q) begin
        pos_d   = bus.fifo_data;
        state_d = RD_MIN;
      end
      RD_MIN: if (pend_q) begin
        raw_d   = bus.fifo_data;
        state_d = CHECK;
      end
      CHECK: begin
        err     = |raw_q[31:WIDTH];
        state_d = err ? IDLE : EMIT;
      end
      EMIT: if (bus.res_ready) begin
        hs      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // one outstanding read; next read may issue in the capture cycle
    rd_st  = state_d inside {RD_QID, RD_POS, RD_MIN};
    rden_d = rd_st && !rden_q && !bus.fifo_empty;
    pend_d = rden_q && !bus.fifo_empty;
  end

  always_comb begin
    nres_d = clear ? '0 : nres_q;
    nerr_d = clear ? '0 : nerr_q;
    ferr_d = clear ? 1'b0 : ferr_q;
    if (hs) nres_d = nres_d + CNT_WIDTH'(1);
    if (err) begin
      nerr_d = nerr_d + CNT_WIDTH'(1);
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rden_q  <= 1'b0;
      pend_q  <= 1'b0;
      qid_q   <= '0;
      pos_q   <= '0;
      raw_q   <= '0;
      nres_q  <= '0;
      nerr_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rden_q  <= rden_d;
      pend_q  <= pend_d;
      qid_q   <= qid_d;
      pos_q   <= pos_d;
      raw_q   <= raw_d;
      nres_q  <= nres_d;
      nerr_q  <= nerr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    rec        = '0;
    rec.qid    = qid_q;
    rec.pos    = pos_q;
    rec.minval[WIDTH-1:0] = raw_q[WIDTH-1:0];
  end

  dtw_result_best #(.WIDTH(WIDTH)) u_best (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .upd         (hs),
    .rec         (rec),
    .best_valid  (best_valid),
    .best_qid    (best_qid),
    .best_pos    (best_pos),
    .best_minval (best_minval)
  );

  assign bus.fifo_rden  = rden_q;
  assign bus.res_valid  = (state_q == EMIT);
  assign bus.res_qid    = qid_q;
  assign bus.res_pos    = pos_q;
  assign bus.res_minval = raw_q[WIDTH-1:0];
  assign n_results      = nres_q;
  assign n_errors       = nerr_q;
  assign frame_err      = ferr_q;

endmodule

// File: tb/tb_dtw_result_reader.sv
// Bench for dtw_result_reader: FIFO model, record scoreboard,
// vector table for best/error tracking, corner-case sequences.
module tb_dtw_result_reader;
  import dtw_pkg::*;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic             best_valid, frame_err;
  logic [31:0]      best_qid, best_pos;
  logic [31:0]      n_results, n_errors;
  logic [WIDTH-1:0] best_minval;

  dtw_result_reader_if #(.WIDTH(WIDTH)) bus();

  dtw_result_reader #(.WIDTH(WIDTH), .CNT_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear       (clear),
    .bus         (bus),
    .best_valid  (best_valid),
    .best_qid    (best_qid),
    .best_pos    (best_pos),
    .best_minval (best_minval),
    .n_results   (n_results),
    .n_errors    (n_errors),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] qid;
    logic [31:0] pos;
    logic [31:0] minw;
    bit          err;
  } vec_t;

  typedef struct {
    logic [31:0]      qid;
    logic [31:0]      pos;
    logic [WIDTH-1:0] minv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  int          tests = 0;
  int          fails = 0;
  int          hs_cnt = 0;
  int          cyc = 0;
  bit          gate = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push_rec(logic [31:0] q, logic [31:0] p,
                          logic [31:0] m, bit ok);
    exp_t e;
    logic [31:0] w[REC_WORDS];
    w[W_QID] = q;
    w[W_POS] = p;
    w[W_MIN] = m;
    for (int i = 0; i < REC_WORDS; i++) fifo_q.push_back(w[i]);
    if (ok) begin
      e.qid  = q;
      e.pos  = p;
      e.minv = m[WIDTH-1:0];
      exp_q.push_back(e);
    end
  endtask

  // FIFO model: 1-cycle read latency, optional empty gating
  initial begin
    bit acc;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    forever begin
      @(posedge clk);
      acc = bus.fifo_rden && !bus.fifo_empty;
      cyc++;
      #1;
      if (acc && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
      bus.fifo_empty = (fifo_q.size() == 0) ||
                       (gate && ((cyc & 2) != 0));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.res_valid && bus.res_ready) begin
      hs_cnt++;
      chk("rec_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rec_qid", bus.res_qid, e.qid);
        chk("rec_pos", bus.res_pos, e.pos);
        chk("rec_min", bus.res_minval, e.minv);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(int n, int budget);
    for (int i = 0; i < budget && hs_cnt < n; i++) @(negedge clk);
    chk("hs_count", hs_cnt, n);
  endtask

  task automatic wait_valid(int budget);
    @(negedge clk);
    for (int i = 0; i < budget && !bus.res_valid; i++) @(negedge clk);
    chk("res_valid_wait", bus.res_valid, 1);
  endtask

  task automatic check_zero(string t);
    chk({t, "_rden"}, bus.fifo_rden, 0);
    chk({t, "_valid"}, bus.res_valid, 0);
    chk({t, "_qid"}, bus.res_qid, 0);
    chk({t, "_pos"}, bus.res_pos, 0);
    chk({t, "_min"}, bus.res_minval, 0);
    chk({t, "_bvalid"}, best_valid, 0);
    chk({t, "_bqid"}, best_qid, 0);
    chk({t, "_bmin"}, best_minval, 0);
    chk({t, "_nres"}, n_results, 0);
    chk({t, "_nerr"}, n_errors, 0);
    chk({t, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    vec_t        vt[5];
    int          tgt;
    int          m_n, m_e;
    bit          m_f, m_bv;
    logic [31:0] m_bq;
    logic [15:0] m_bm;

    vt[0] = '{32'd1, 32'h100, 32'h0000_0040, 1'b0};
    vt[1] = '{32'd2, 32'h200, 32'h0000_0030, 1'b0};
    vt[2] = '{32'd3, 32'h300, 32'h0000_0030, 1'b0};
    vt[3] = '{32'd4, 32'h400, 32'h0001_0005, 1'b1};
    vt[4] = '{32'd5, 32'h500, 32'h0000_0020, 1'b0};
    bus.res_ready = 1'b1;
    tgt = 0;

    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_zero("reset");
    step();
    rst = 1'b0;
    enable = 1'b1;

    // single record
    push_rec(32'h7, 32'h1234, 32'h50, 1'b1);
    tgt += 1;
    wait_hs(tgt, 60);
    @(negedge clk);
    chk("single_nres", n_results, 1);
    chk("single_bvalid", best_valid, 1);
    chk("single_bqid", best_qid, 32'h7);
    chk("single_bpos", best_pos, 32'h1234);
    chk("single_bmin", best_minval, 16'h50);

    // backpressure with a second triple queued
    step();
    bus.res_ready = 1'b0;
    push_rec(32'h21, 32'h2100, 32'h70, 1'b1);
    push_rec(32'h22, 32'h2200, 32'h60, 1'b1);
    wait_valid(60);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_qid", bus.res_qid, 32'h21);
      chk("bp_min", bus.res_minval, 16'h70);
      chk("bp_rden", bus.fifo_rden, 0);
    end
    chk("bp_fifo_left", fifo_q.size(), 3);
    chk("bp_no_hs", hs_cnt, tgt);
    step();
    bus.res_ready = 1'b1;
    tgt += 2;
    wait_hs(tgt, 80);
    @(negedge clk);
    chk("bp_nres", n_results, 3);
    chk("bp_bmin", best_minval, 16'h50);

    // vector table: best update, tie, framing error
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_nres", n_results, 0);
    chk("clr_bvalid", best_valid, 0);
    m_n = 0; m_e = 0; m_f = 0; m_bv = 0; m_bq = 0; m_bm = 0;
    for (int i = 0; i < 5; i++) begin
      push_rec(vt[i].qid, vt[i].pos, vt[i].minw, !vt[i].err);
      if (vt[i].err) begin
        m_e++;
        m_f = 1'b1;
      end else begin
        m_n++;
        tgt++;
        if (!m_bv || vt[i].minw[15:0] < m_bm) begin
          m_bv = 1'b1;
          m_bq = vt[i].qid;
          m_bm = vt[i].minw[15:0];
        end
      end
      repeat (14) @(negedge clk);
      wait_hs(tgt, 40);
      @(negedge clk);
      chk("vec_nres", n_results, m_n);
      chk("vec_nerr", n_errors, m_e);
      chk("vec_ferr", frame_err, m_f);
      chk("vec_bqid", best_qid, m_bq);
      chk("vec_bmin", best_minval, m_bm);
    end

    // FIFO starvation
    gate = 1'b1;
    push_rec(32'hA, 32'hB, 32'hC, 1'b1);
    tgt++;
    m_n++;
    wait_hs(tgt, 200);
    gate = 1'b0;
    @(negedge clk);
    chk("starve_nres", n_results, m_n);
    chk("starve_fifo", fifo_q.size(), 0);
    chk("starve_bmin", best_minval, 16'hC);

    // clear in the same cycle as the handshake
    step();
    bus.res_ready = 1'b0;
    push_rec(32'h11, 32'h22, 32'h90, 1'b1);
    tgt++;
    wait_valid(60);
    step();
    bus.res_ready = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clrhs_hs", hs_cnt, tgt);
    chk("clrhs_nres", n_results, 1);
    chk("clrhs_nerr", n_errors, 0);
    chk("clrhs_ferr", frame_err, 0);
    chk("clrhs_bvalid", best_valid, 1);
    chk("clrhs_bqid", best_qid, 32'h11);
    chk("clrhs_bmin", best_minval, 16'h90);

    // reset after the qid word, then a fresh triple
    fifo_q.push_back(32'h99);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    fifo_q.delete();
    push_rec(32'h33, 32'h44, 32'h55, 1'b1);
    tgt++;
    wait_hs(tgt, 60);
    @(negedge clk);
    chk("rst_nres", n_results, 1);
    chk("rst_bqid", best_qid, 32'h33);
    chk("rst_bpos", best_pos, 32'h44);
    chk("rst_bmin", best_minval, 16'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dtw_result_reader.md
Name: dtw_result_reader

Overview:
- Consumer at the sink end of the DTW core's result stream. Drains the 32-bit result FIFO the core writes: three words per query, in the order qid, position, {16'b0, minval}.
- Reassembles each triple into one result record and hands it downstream on a valid/ready interface.
- Keeps running statistics for the host: record count, best (lowest) score with its qid/position, and framing-error detection.

Parameters:
- WIDTH, 16, score width; must be <= 16. The minval word carries the score in bits [WIDTH-1:0]; bits [31:WIDTH] must be zero.
- CNT_WIDTH, 32, width of the n_results and n_errors counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  allows a new record to start; sampled only in IDLE
- clear  in  1  one-cycle pulse; zeroes the statistics only
- fifo_rden  out  1  result FIFO read enable
- fifo_empty  in  1  result FIFO empty
- fifo_data  in  32  result FIFO data; valid the cycle after an accepted read
- res_valid  out  1  record available
- res_ready  in  1  downstream accepts the record
- res_qid  out  32  record query id
- res_pos  out  32  record best-match position
- res_minval  out  WIDTH  record score
- best_valid  out  1  at least one record seen since reset/clear
- best_qid  out  32  qid of the lowest score
- best_pos  out  32  position of the lowest score
- best_minval  out  WIDTH  lowest score
- n_results  out  CNT_WIDTH  records emitted
- n_errors  out  CNT_WIDTH  records dropped for framing errors
- frame_err  out  1  sticky framing-error flag

Behaviour:
- Reset values: every output is 0, including fifo_rden, res_valid, best_valid, frame_err, both counters and all data outputs. State is IDLE.
- FIFO read protocol (1-cycle read latency):
  - A read is accepted when fifo_rden=1 and fifo_empty=0 in the same cycle.
  - fifo_data is captured on the following cycle.
  - At most one read is outstanding; fifo_rden is a registered, single-cycle pulse.
  - Minimum cost is 2 cycles per word.
- State machine (states IDLE, RD_QID, RD_POS, RD_MIN, CHECK, EMIT):
  - IDLE: go to RD_QID when enable=1; otherwise stay.
  - RD_QID / RD_POS / RD_MIN: issue a read when no read is outstanding and fifo_empty=0. Capture into qid, pos or the raw min word respectively, then advance.
  - An empty FIFO stalls the current state indefinitely; no timeout.
  - CHECK (1 cycle): if raw_min[31:WIDTH] != 0, set frame_err, increment n_errors, drop the record, go to IDLE. Otherwise go to EMIT.
  - EMIT: res_valid=1 with res_* stable until res_ready=1. On that handshake cycle: clear res_valid, increment n_results, update best, go to IDLE.
  - No FIFO reads are issued in EMIT; downstream backpressure propagates to the FIFO.
- Deasserting enable mid-record does not abort the record; it only blocks the next one from starting in IDLE.
- Best tracking, evaluated on the EMIT handshake:
  - Replace best if best_valid=0 or res_minval < best_minval (strict compare; ties keep the earlier record).
  - best_valid is set on the first replacement.
- clear:
  - Zeroes best_*, best_valid, n_results, n_errors and frame_err on the next edge.
  - Does not affect the state machine or an in-flight record.
  - If clear and an EMIT handshake occur in the same cycle, the handshake wins: counters become 1 and best takes the emitted record.
- Counters wrap modulo 2^CNT_WIDTH without flagging.
- rst mid-record: returns to IDLE; a word read but not yet captured is lost. Host software resynchronises by clearing the FIFO, matching the core's IDLE-state FIFO clear.
- Throughput: at least 8 cycles per record, which is negligible against DTW runtime.

Decomposition:
- Shared package dtw_pkg:
  - Result word indices: QID=0, POS=1, MIN=2, and the record length constant 3.
  - A state enum type.
  - A result record struct {qid, pos, minval}, reused by the core's writer side.
- One natural sub-module: dtw_result_best, the best-score tracker (compare/update plus clear priority). Everything else stays in one module.

Test Plan:
- Single record: after reset, enable=1; FIFO holds 0x7, 0x1234, 0x00000050 -> res_valid with qid=7, pos=0x1234, minval=0x50; n_results=1; best = {7, 0x1234, 0x50}.
- Backpressure: res_ready low for 20 cycles with a second triple queued -> res_* stable; fifo_rden stays 0 during EMIT; second record emitted only after the first handshake.
- Best update and tie: scores 0x40, 0x30, 0x30 (qids 1, 2, 3) -> best_qid=2, best_minval=0x30; n_results=3.
- Framing error: min word 0x00010005 -> no res_valid; frame_err=1; n_errors=1; the next valid triple is emitted normally.
- FIFO starvation: empty toggles every other cycle during a triple -> correct record; no duplicate or skipped words.
- clear coincident with handshake, and rst mid-record: clear in the handshake cycle -> n_results=1, best = that record. rst after the qid word -> all outputs 0; the FIFO is refilled with a full triple, which is decoded correctly.
